// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/LSU requesters and the shared RAM port arbiter.
// master = requester side, slave = arbiter side.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        if_rsp_valid;
  logic        lsu_rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output if_req_valid, if_addr,
    output lsu_req_valid, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    input  if_req_ready, lsu_req_ready,
    input  if_rsp_valid, lsu_rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  if_req_valid, if_addr,
    input  lsu_req_valid, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    output if_req_ready, lsu_req_ready,
    output if_rsp_valid, lsu_rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed sync RAM port between instruction fetch and the load/store unit,
// rejecting illegal accesses with an error response and no RAM activity.
//
// state  | meaning
// IDLE   | ready toward the selected requester; accept latches the request
// ISSUE  | address/controls driven to RAM (store write happens here)
// RESP   | one-cycle response pulse to the latched requester
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int ARB_MODE   = 0,
  parameter int RESET_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic               ram_we,
  output logic [2:0]         ram_wr_ctrl,
  output logic [2:0]         ram_rd_ctrl,
  output logic [31:0]        ram_addr,
  output logic [31:0]        ram_wr_data,
  input  logic [31:0]        ram_rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [2:0] SZ_W    = 3'b010;

  logic [1:0]  state;
  logic        prio_lsu;
  logic        id_lsu_q;
  logic        we_q;
  logic        err_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        grant_any;
  logic        grant_lsu;
  logic        sel_we;
  logic [2:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        in_idle;
  logic        in_issue;
  logic        in_resp;

  function automatic logic is_illegal(input logic we, input logic [2:0] size,
                                      input logic [31:0] addr);
    logic bad;
    bad = (size == 3'b011) || (size == 3'b110) || (size == 3'b111) || (we && size[2]);
    if ((size[1:0] == 2'b01) && addr[0])
      bad = 1'b1;
    if ((size[1:0] == 2'b10) && (addr[1:0] != 2'b00))
      bad = 1'b1;
    if (addr[31:ADDR_W] != '0)
      bad = 1'b1;
    return bad;
  endfunction

  always_comb begin
    grant_any = bus.if_req_valid | bus.lsu_req_valid;
    if (bus.if_req_valid && bus.lsu_req_valid)
      grant_lsu = (ARB_MODE == 1) ? 1'b1 : prio_lsu;
    else
      grant_lsu = bus.lsu_req_valid;
    // Fetches are always word reads with no write data.
    sel_we    = grant_lsu ? bus.lsu_we    : 1'b0;
    sel_size  = grant_lsu ? bus.lsu_size  : SZ_W;
    sel_addr  = grant_lsu ? bus.lsu_addr  : bus.if_addr;
    sel_wdata = grant_lsu ? bus.lsu_wdata : '0;
    sel_err   = is_illegal(sel_we, sel_size, sel_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      prio_lsu <= (RESET_PRIO != 0);
      id_lsu_q <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_W;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            id_lsu_q <= grant_lsu;
            we_q     <= sel_we;
            size_q   <= sel_size;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            err_q    <= sel_err;
            prio_lsu <= ~grant_lsu;
            state    <= sel_err ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_idle  = (state == S_IDLE) && !rst;
    in_issue = (state == S_ISSUE) && !rst;
    in_resp  = (state == S_RESP) && !rst;

    bus.if_req_ready  = in_idle && bus.if_req_valid && !grant_lsu;
    bus.lsu_req_ready = in_idle && bus.lsu_req_valid && grant_lsu;

    ram_we      = in_issue && we_q;
    ram_addr    = in_issue ? addr_q : '0;
    ram_wr_ctrl = in_issue ? size_q : SZ_W;
    ram_rd_ctrl = in_issue ? size_q : SZ_W;
    ram_wr_data = (in_issue && we_q) ? wdata_q : '0;

    // RAM read data is registered, so it lines up with the RESP cycle.
    bus.if_rsp_valid  = in_resp && !id_lsu_q;
    bus.lsu_rsp_valid = in_resp && id_lsu_q;
    bus.rsp_err       = in_resp && err_q;
    bus.rsp_data      = (in_resp && !err_q && !we_q) ? ram_rd_data : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + constrained-random bench for mem_port_arbiter with a byte-array RAM and reference model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if b();
  mem_port_arbiter_if b1();

  logic        ram_we;
  logic [2:0]  ram_wr_ctrl, ram_rd_ctrl;
  logic [31:0] ram_addr, ram_wr_data;
  logic [31:0] ram_rd_data = '0;

  logic        r1_we;
  logic [2:0]  r1_wc, r1_rc;
  logic [31:0] r1_addr, r1_wd;
  logic [31:0] r1_rd = '0;

  mem_port_arbiter #(.ADDR_W(12), .ARB_MODE(0), .RESET_PRIO(0)) dut (
    .clk(clk), .rst(rst), .bus(b.slave),
    .ram_we(ram_we), .ram_wr_ctrl(ram_wr_ctrl), .ram_rd_ctrl(ram_rd_ctrl),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  mem_port_arbiter #(.ADDR_W(12), .ARB_MODE(1), .RESET_PRIO(0)) dut_fixed (
    .clk(clk), .rst(rst), .bus(b1.slave),
    .ram_we(r1_we), .ram_wr_ctrl(r1_wc), .ram_rd_ctrl(r1_rc),
    .ram_addr(r1_addr), .ram_wr_data(r1_wd), .ram_rd_data(r1_rd)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] ram_mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic       ram_init = 1'b0;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] sz);
    logic [31:0] s;
    s = w >> (8 * a);
    case (sz)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Sync RAM: registered read of the presented address, write on ram_we.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= 8'h00;
      ram_mem[16] <= 8'hEF; ram_mem[17] <= 8'hBE; ram_mem[18] <= 8'hAD; ram_mem[19] <= 8'hDE;
    end else begin
      ram_rd_data <= ext({ram_mem[{ram_addr[11:2], 2'b11}], ram_mem[{ram_addr[11:2], 2'b10}],
                          ram_mem[{ram_addr[11:2], 2'b01}], ram_mem[{ram_addr[11:2], 2'b00}]},
                         ram_addr[1:0], ram_rd_ctrl);
      if (ram_we) begin
        ram_mem[ram_addr[11:0]] <= ram_wr_data[7:0];
        if (ram_wr_ctrl[1:0] != 2'b00) ram_mem[{ram_addr[11:1], 1'b1}] <= ram_wr_data[15:8];
        if (ram_wr_ctrl[1:0] == 2'b10) begin
          ram_mem[{ram_addr[11:2], 2'b10}] <= ram_wr_data[23:16];
          ram_mem[{ram_addr[11:2], 2'b11}] <= ram_wr_data[31:24];
        end
      end
    end
  end

  function automatic bit ref_bad(input bit we, input logic [2:0] sz, input logic [31:0] a);
    bit oor;
    oor = (a >= 32'h1000);
    case (sz)
      3'b000:  return oor;
      3'b100:  return we || oor;
      3'b001:  return a[0] || oor;
      3'b101:  return we || a[0] || oor;
      3'b010:  return (a[1:0] != 2'b00) || oor;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_ld(input logic [31:0] a, input logic [2:0] sz);
    logic [11:0] bs;
    bs = {a[11:2], 2'b00};
    return ext({ref_mem[bs + 12'd3], ref_mem[bs + 12'd2], ref_mem[bs + 12'd1], ref_mem[bs]}, a[1:0], sz);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input bit lsu, input bit we, input logic [2:0] size, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [31:0] exp_data, input bit exp_err,
                    input string tag);
    int   n;
    logic rdy;
    @(negedge clk);
    if (lsu) begin
      b.lsu_req_valid = 1'b1; b.lsu_we = we; b.lsu_size = size;
      b.lsu_addr = addr; b.lsu_wdata = wdata;
    end else begin
      b.if_req_valid = 1'b1; b.if_addr = addr;
    end
    #1;
    n = 0;
    rdy = lsu ? b.lsu_req_ready : b.if_req_ready;
    while (!rdy && n < 8) begin
      @(negedge clk); #1; n++;
      rdy = lsu ? b.lsu_req_ready : b.if_req_ready;
    end
    chk({tag, " ready"}, {31'd0, rdy}, 32'd1);
    @(negedge clk);
    b.if_req_valid = 1'b0; b.lsu_req_valid = 1'b0;
    b.if_addr = $urandom; b.lsu_addr = $urandom; b.lsu_wdata = $urandom;
    b.lsu_size = 3'($urandom); b.lsu_we = 1'($urandom);
    #1;
    if (!exp_err) begin
      chk({tag, " ram_addr"}, ram_addr, addr);
      chk({tag, " ram_we"}, {31'd0, ram_we}, {31'd0, we});
      chk({tag, " rd_ctrl"}, {29'd0, ram_rd_ctrl}, {29'd0, (lsu ? size : 3'b010)});
      if (we) chk({tag, " wr_data"}, ram_wr_data, wdata);
      chk({tag, " early rsp"}, {30'd0, b.if_rsp_valid, b.lsu_rsp_valid}, 32'd0);
      @(negedge clk); #1;
    end
    chk({tag, " we in resp"}, {31'd0, ram_we}, 32'd0);
    chk({tag, " rsp_valid"}, {30'd0, b.if_rsp_valid, b.lsu_rsp_valid}, lsu ? 32'd1 : 32'd2);
    chk({tag, " rsp_err"}, {31'd0, b.rsp_err}, {31'd0, exp_err});
    chk({tag, " rsp_data"}, b.rsp_data, exp_data);
    if (lsu && we && !exp_err) begin
      ref_mem[addr[11:0]] = wdata[7:0];
      if (size[1:0] != 2'b00) ref_mem[addr[11:0] + 12'd1] = wdata[15:8];
      if (size[1:0] == 2'b10) begin
        ref_mem[addr[11:0] + 12'd2] = wdata[23:16];
        ref_mem[addr[11:0] + 12'd3] = wdata[31:24];
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, cyc, g_lsu, g_if, r_lsu, r_if;
    logic [3:0]  seq;
    bit          both, baddata, lsu, we, e;
    logic [2:0]  sz;
    logic [31:0] a, wd, d;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;

    b1.if_req_valid = 1'b1; b1.if_addr = 32'h4;
    b1.lsu_req_valid = 1'b1; b1.lsu_we = 1'b0; b1.lsu_size = 3'b010;
    b1.lsu_addr = 32'h0; b1.lsu_wdata = 32'h0;

    rst = 1'b1; ram_init = 1'b1;
    b.if_req_valid = 1'b1; b.if_addr = 32'h10;
    b.lsu_req_valid = 1'b1; b.lsu_we = 1'b1; b.lsu_size = 3'b010;
    b.lsu_addr = 32'h20; b.lsu_wdata = 32'h1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset if_ready", {31'd0, b.if_req_ready}, 32'd0);
    chk("reset lsu_ready", {31'd0, b.lsu_req_ready}, 32'd0);
    chk("reset ram_we", {31'd0, ram_we}, 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    chk("reset rd_ctrl", {29'd0, ram_rd_ctrl}, 32'd2);
    chk("reset wr_ctrl", {29'd0, ram_wr_ctrl}, 32'd2);
    chk("reset rsp", {29'd0, b.if_rsp_valid, b.lsu_rsp_valid, b.rsp_err}, 32'd0);
    chk("reset rsp_data", b.rsp_data, 32'd0);
    b.if_req_valid = 1'b0; b.lsu_req_valid = 1'b0;
    rst = 1'b0; ram_init = 1'b0;

    // Fixed-priority instance: both always valid, LSU should take every grant.
    g_lsu = 0; g_if = 0; r_lsu = 0; r_if = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      g_lsu += int'(b1.lsu_req_ready); g_if += int'(b1.if_req_ready);
      r_lsu += int'(b1.lsu_rsp_valid); r_if += int'(b1.if_rsp_valid);
      @(negedge clk);
    end
    chk("fixed lsu grants", g_lsu, 32'd4);
    chk("fixed if grants", g_if, 32'd0);
    chk("fixed lsu rsps", r_lsu, 32'd4);
    chk("fixed if rsps", r_if, 32'd0);

    op(0, 0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 0, "fetch 0x010");
    op(1, 1, 3'b010, 32'h020, 32'h12345678, 32'h0, 0, "store W 0x020");
    op(1, 0, 3'b100, 32'h023, 32'h0, 32'h00000012, 0, "load BU 0x023");
    op(1, 0, 3'b000, 32'h023, 32'h0, 32'h00000012, 0, "load B 0x023");
    op(1, 1, 3'b000, 32'h023, 32'h00000080, 32'h0, 0, "store B 0x023");
    op(1, 0, 3'b100, 32'h023, 32'h0, 32'h00000080, 0, "load BU 0x80");
    op(1, 0, 3'b000, 32'h023, 32'h0, 32'hFFFFFF80, 0, "load B 0x80");
    op(1, 0, 3'b101, 32'h022, 32'h0, 32'h00008034, 0, "load HU 0x022");
    op(1, 0, 3'b001, 32'h022, 32'h0, 32'hFFFF8034, 0, "load H 0x022");
    op(1, 0, 3'b010, 32'h020, 32'h0, 32'h80345678, 0, "load W 0x020");

    op(1, 0, 3'b001, 32'h001, 32'h0, 32'h0, 1, "illegal H 0x001");
    op(1, 0, 3'b010, 32'h002, 32'h0, 32'h0, 1, "illegal W 0x002");
    op(1, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, "illegal W 0x1000");
    op(1, 1, 3'b100, 32'h020, 32'hAAAAAAAA, 32'h0, 1, "illegal store sz100");
    op(1, 1, 3'b111, 32'h020, 32'h55555555, 32'h0, 1, "illegal sz111");
    op(1, 0, 3'b010, 32'h020, 32'h0, 32'h80345678, 0, "reload after illegal");

    // Round-robin ties: last grant was LSU, so IF goes first.
    b.if_addr = 32'h10; b.lsu_we = 1'b0; b.lsu_size = 3'b010; b.lsu_addr = 32'h20;
    @(negedge clk);
    b.if_req_valid = 1'b1; b.lsu_req_valid = 1'b1;
    n = 0; cyc = 0; seq = '0; both = 0; baddata = 0;
    while (n < 4 && cyc < 30) begin
      #1;
      if (b.if_rsp_valid && b.lsu_rsp_valid) both = 1;
      if (b.if_rsp_valid || b.lsu_rsp_valid) begin
        seq = {seq[2:0], b.lsu_rsp_valid};
        if (b.rsp_data !== (b.lsu_rsp_valid ? 32'h80345678 : 32'hDEADBEEF)) baddata = 1;
        n++;
      end
      if (n == 4) begin b.if_req_valid = 1'b0; b.lsu_req_valid = 1'b0; end
      @(negedge clk);
      cyc++;
    end
    b.if_req_valid = 1'b0; b.lsu_req_valid = 1'b0;
    chk("rr response count", n, 32'd4);
    chk("rr order", {28'd0, seq}, 32'h5);
    chk("rr both valid", {31'd0, both}, 32'd0);
    chk("rr data", {31'd0, baddata}, 32'd0);

    // Reset during ISSUE of a store kills it with no response.
    b.lsu_req_valid = 1'b1; b.lsu_we = 1'b1; b.lsu_size = 3'b010;
    b.lsu_addr = 32'h030; b.lsu_wdata = 32'hCAFEF00D;
    #1;
    chk("kill accept", {31'd0, b.lsu_req_ready}, 32'd1);
    @(negedge clk);
    b.lsu_req_valid = 1'b0;
    #1;
    chk("kill we before rst", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("kill we", {31'd0, ram_we}, 32'd0);
    chk("kill addr", ram_addr, 32'd0);
    chk("kill wr_data", ram_wr_data, 32'd0);
    chk("kill rd_ctrl", {29'd0, ram_rd_ctrl}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    // After release, first tie must go to IF.
    b.if_addr = 32'h10; b.lsu_we = 1'b0; b.lsu_size = 3'b010; b.lsu_addr = 32'h20;
    b.if_req_valid = 1'b1; b.lsu_req_valid = 1'b1;
    n = 0; cyc = 0; both = 0;
    while (n == 0 && cyc < 10) begin
      #1;
      if (b.if_rsp_valid || b.lsu_rsp_valid) begin
        n = 1; both = b.lsu_rsp_valid;
        b.if_req_valid = 1'b0; b.lsu_req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    b.if_req_valid = 1'b0; b.lsu_req_valid = 1'b0;
    chk("post-rst rsp seen", n, 32'd1);
    chk("post-rst tie to IF", {31'd0, both}, 32'd0);
    op(1, 0, 3'b010, 32'h030, 32'h0, 32'h0, 0, "0x030 unchanged");

    // Random back-to-back mix against the byte-array model.
    for (int i = 0; i < 40; i++) begin
      lsu = ($urandom_range(0, 2) != 0);
      if (lsu) begin
        we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: sz = 3'b000; 1: sz = 3'b001; 2: sz = 3'b010; 3: sz = 3'b100;
          4: sz = 3'b101; 5: sz = 3'b010; 6: sz = 3'b001; default: sz = 3'b111;
        endcase
        a = 32'h40 + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) a = a | 32'h1000;
      end else begin
        we = 1'b0; sz = 3'b010;
        a = 32'h40 + 32'($urandom_range(0, 7)) * 4;
        if ($urandom_range(0, 7) == 0) a = a + 32'd1;
      end
      wd = $urandom;
      e = ref_bad(we, sz, a);
      d = (e || we) ? 32'h0 : ref_ld(a, sz);
      op(lsu, we, sz, a, wd, d, e, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
